// File: rtl/gpu_divider_iter_if.sv
// Request/result handshake bundle for gpu_divider_iter.
// o_remainder only exists when DIVIDER_REMAINDER_EN is defined.
interface gpu_divider_iter_if #(
   parameter int WIDTH = 32
);
   logic             i_valid;
   logic             o_ready;
   logic             i_signed;
   logic [WIDTH-1:0] i_numerator;
   logic [WIDTH-1:0] i_denominator;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_quotient;
`ifdef DIVIDER_REMAINDER_EN
   logic [WIDTH-1:0] o_remainder;
`endif
   logic             o_divzero;

   modport slave (
      input  i_valid, i_signed, i_numerator, i_denominator, i_ready,
      output o_ready, o_valid, o_quotient,
`ifdef DIVIDER_REMAINDER_EN
      output o_remainder,
`endif
      output o_divzero
   );

   modport master (
      output i_valid, i_signed, i_numerator, i_denominator, i_ready,
      input  o_ready, o_valid, o_quotient,
`ifdef DIVIDER_REMAINDER_EN
      input  o_remainder,
`endif
      input  o_divzero
   );
endinterface

// File: rtl/gpu_divider_iter.sv
// Iterative restoring divider, STEPS quotient bits per clock, signed/unsigned.
// Optional remainder output and its sign correction: macro DIVIDER_REMAINDER_EN.
module gpu_divider_iter #(
   parameter int WIDTH = 32,
   parameter int STEPS = 1
) (
   input  logic               clk,
   input  logic               nRst,
   gpu_divider_iter_if.slave  bus
);
   localparam int NSTEPS = WIDTH / STEPS;
   localparam int CNT_W  = $clog2(NSTEPS + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_den;
   logic             r_qneg;
   logic [WIDTH-1:0] r_quotient;
   logic             r_divzero;
`ifdef DIVIDER_REMAINDER_EN
   logic             r_rneg;
   logic [WIDTH-1:0] r_remainder;
`endif

   logic             w_num_neg;
   logic             w_den_neg;
   logic [WIDTH-1:0] w_num_abs;
   logic [WIDTH-1:0] w_den_abs;

   assign w_num_neg = bus.i_signed & bus.i_numerator[WIDTH-1];
   assign w_den_neg = bus.i_signed & bus.i_denominator[WIDTH-1];
   assign w_num_abs = w_num_neg ? -bus.i_numerator   : bus.i_numerator;
   assign w_den_abs = w_den_neg ? -bus.i_denominator : bus.i_denominator;

   // Partial remainder / shifting dividend pass through STEPS chained stages.
   logic [WIDTH-1:0] w_rem_chain [STEPS+1];
   logic [WIDTH-1:0] w_quo_chain [STEPS+1];

   assign w_rem_chain[0] = r_rem;
   assign w_quo_chain[0] = r_quo;

   generate
      for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
         logic [WIDTH:0]   w_shift;
         logic [WIDTH-1:0] w_diff;
         logic             w_fits;

         assign w_shift = {w_rem_chain[gi], w_quo_chain[gi][WIDTH-1]};
         assign w_fits  = (w_shift >= {1'b0, r_den});
         // When the trial fits, the difference is below r_den and needs only WIDTH bits.
         assign w_diff  = w_shift[WIDTH-1:0] - r_den;
         assign w_rem_chain[gi+1] = w_fits ? w_diff : w_shift[WIDTH-1:0];
         assign w_quo_chain[gi+1] = {w_quo_chain[gi][WIDTH-2:0], w_fits};
      end
   endgenerate

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_den      <= '0;
         r_qneg     <= 1'b0;
         r_quotient <= '0;
         r_divzero  <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
         r_rneg      <= 1'b0;
         r_remainder <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.i_valid) begin
                  if (bus.i_denominator == '0) begin
                     r_quotient <= '1;
                     r_divzero  <= 1'b1;
`ifdef DIVIDER_REMAINDER_EN
                     r_remainder <= bus.i_numerator;
`endif
                     r_state    <= DONE;
                  end else begin
                     r_rem   <= '0;
                     r_quo   <= w_num_abs;
                     r_den   <= w_den_abs;
                     r_qneg  <= w_num_neg ^ w_den_neg;
`ifdef DIVIDER_REMAINDER_EN
                     r_rneg  <= w_num_neg;
`endif
                     r_cnt   <= CNT_W'(NSTEPS);
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_rem <= w_rem_chain[STEPS];
               r_quo <= w_quo_chain[STEPS];
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  // Most-negative / -1 wraps back to most-negative here naturally.
                  r_quotient <= r_qneg ? -w_quo_chain[STEPS] : w_quo_chain[STEPS];
`ifdef DIVIDER_REMAINDER_EN
                  r_remainder <= r_rneg ? -w_rem_chain[STEPS] : w_rem_chain[STEPS];
`endif
                  r_divzero  <= 1'b0;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (bus.i_ready) begin
                  r_divzero <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.o_ready    = (r_state == IDLE);
   assign bus.o_valid    = (r_state == DONE);
   assign bus.o_quotient = r_quotient;
   assign bus.o_divzero  = r_divzero;
`ifdef DIVIDER_REMAINDER_EN
   assign bus.o_remainder = r_remainder;
`endif
endmodule

// File: tb/tb_gpu_divider_iter.sv
// Directed bench for gpu_divider_iter: one STEPS=1 and one STEPS=4 instance, WIDTH=32.
// Remainder checks are active when DIVIDER_REMAINDER_EN is defined.
module tb_gpu_divider_iter;
   logic clk;
   logic nRst;

   gpu_divider_iter_if #(.WIDTH(32)) if1 ();
   gpu_divider_iter_if #(.WIDTH(32)) if4 ();

   gpu_divider_iter #(.WIDTH(32), .STEPS(1)) dut1 (.clk(clk), .nRst(nRst), .bus(if1));
   gpu_divider_iter #(.WIDTH(32), .STEPS(4)) dut4 (.clk(clk), .nRst(nRst), .bus(if4));

   logic        sel;
   logic        tb_valid;
   logic        tb_signed;
   logic [31:0] tb_num;
   logic [31:0] tb_den;
   logic        tb_rdy;

   assign if1.i_valid       = tb_valid & ~sel;
   assign if1.i_ready       = tb_rdy & ~sel;
   assign if1.i_signed      = tb_signed;
   assign if1.i_numerator   = tb_num;
   assign if1.i_denominator = tb_den;
   assign if4.i_valid       = tb_valid & sel;
   assign if4.i_ready       = tb_rdy & sel;
   assign if4.i_signed      = tb_signed;
   assign if4.i_numerator   = tb_num;
   assign if4.i_denominator = tb_den;

   logic        obs_valid;
   logic        obs_ready;
   logic [31:0] obs_q;
   logic [31:0] obs_r;
   logic        obs_dz;

   always_comb begin
      obs_valid = sel ? if4.o_valid   : if1.o_valid;
      obs_ready = sel ? if4.o_ready   : if1.o_ready;
      obs_q     = sel ? if4.o_quotient : if1.o_quotient;
      obs_dz    = sel ? if4.o_divzero : if1.o_divzero;
      obs_r     = '0;
`ifdef DIVIDER_REMAINDER_EN
      obs_r     = sel ? if4.o_remainder : if1.o_remainder;
`endif
   end

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!obs_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic run_div(input string tag, input logic s, input logic is_signed,
                          input logic [31:0] n, input logic [31:0] d,
                          input logic [31:0] q_exp, input logic [31:0] r_exp,
                          input logic dz_exp, input int lat_exp);
      int cyc;
      sel = s; tb_signed = is_signed; tb_num = n; tb_den = d; tb_valid = 1'b1;
      @(posedge clk); #1;
      tb_valid = 1'b0;
      tb_num = ~n; tb_den = ~d; tb_signed = ~is_signed;
      check({tag, "_busy"}, 64'(obs_ready), 64'd0);
      wait_valid(cyc);
      check({tag, "_lat"}, 64'(cyc), 64'(lat_exp));
      check({tag, "_q"}, 64'(obs_q), 64'(q_exp));
`ifdef DIVIDER_REMAINDER_EN
      check({tag, "_r"}, 64'(obs_r), 64'(r_exp));
`endif
      check({tag, "_dz"}, 64'(obs_dz), 64'(dz_exp));
      $display("txn %s: n=0x%08h d=0x%08h signed=%0d -> q=0x%08h r=0x%08h dz=%0d lat=%0d",
               tag, n, d, is_signed, obs_q, obs_r, obs_dz, cyc);
      tb_rdy = 1'b1;
      @(posedge clk); #1;
      tb_rdy = 1'b0;
      check({tag, "_idle"}, {63'd0, obs_ready}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      nRst = 1'b0; sel = 1'b0; tb_valid = 1'b0; tb_signed = 1'b0;
      tb_num = '0; tb_den = '0; tb_rdy = 1'b0;
      #3;
      check("rst_ready", 64'(obs_ready), 64'd1);
      check("rst_valid", 64'(obs_valid), 64'd0);
      check("rst_q", 64'(obs_q), 64'd0);
      check("rst_dz", 64'(obs_dz), 64'd0);
      #18 nRst = 1'b1;

      // First accept on the first edge after reset release.
      run_div("s100_m7",   1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 32);
      run_div("uFFFF_3",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0, 1'b0, 8);
      run_div("s_ovf",     1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32);
      run_div("s_m9_0",    1'b0, 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 0);
      run_div("s_m100_7",  1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 8);
      run_div("s_m100_m7", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 8);
      run_div("u100_7",    1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 8);
      run_div("u_big",     1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32);
      run_div("u7_100",    1'b1, 1'b0, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 8);
      run_div("u_div0",    1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);

      // Hold result with i_ready low while inputs churn.
      sel = 1'b0; tb_signed = 1'b1; tb_num = 32'd100; tb_den = 32'hFFFF_FFF9; tb_valid = 1'b1;
      @(posedge clk); #1;
      tb_valid = 1'b0;
      wait_valid(cyc);
      check("hold_lat", 64'(cyc), 64'd32);
      for (int i = 0; i < 10; i++) begin
         tb_valid = ~tb_valid; tb_num = $urandom; tb_den = $urandom; tb_signed = ~tb_signed;
         @(posedge clk); #1;
      end
      check("hold_q", 64'(obs_q), 64'hFFFF_FFF2);
`ifdef DIVIDER_REMAINDER_EN
      check("hold_r", 64'(obs_r), 64'd2);
`endif
      check("hold_valid", 64'(obs_valid), 64'd1);
      check("hold_ready", 64'(obs_ready), 64'd0);
      tb_valid = 1'b1; tb_signed = 1'b0; tb_num = 32'd50; tb_den = 32'd5; tb_rdy = 1'b1;
      @(posedge clk); #1;
      tb_rdy = 1'b0;
      check("bubble_ready", 64'(obs_ready), 64'd1);
      check("bubble_valid", 64'(obs_valid), 64'd0);
      @(posedge clk); #1;
      tb_valid = 1'b0;
      check("bubble_accept", 64'(obs_ready), 64'd0);
      wait_valid(cyc);
      check("bubble_lat", 64'(cyc), 64'd32);
      check("bubble_q", 64'(obs_q), 64'd10);
      $display("txn hold: q=0x%08h r=0x%08h lat=%0d", obs_q, obs_r, cyc);
      tb_rdy = 1'b1;
      @(posedge clk); #1;
      tb_rdy = 1'b0;

      // Reset in the middle of a calculation.
      sel = 1'b0; tb_signed = 1'b0; tb_num = 32'd1000; tb_den = 32'd3; tb_valid = 1'b1;
      @(posedge clk); #1;
      tb_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1 nRst = 1'b0;
      #1;
      check("midrst_valid", 64'(obs_valid), 64'd0);
      check("midrst_ready", 64'(obs_ready), 64'd1);
      check("midrst_q", 64'(obs_q), 64'd0);
      $display("txn midrst: valid=%0d ready=%0d q=0x%08h", obs_valid, obs_ready, obs_q);
      @(negedge clk) nRst = 1'b1;
      run_div("post_rst",  1'b0, 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 32);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
